// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog: counts cycles while enabled, flags the last allowed cycle.
module fetch_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // The owner leaves WAIT/DRAIN on this cycle, so the count never needs to wrap.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding reads, and hands
// fetched words to decode under valid/ready with branch redirect support.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         wd_clear;
  logic         wd_enable;
  logic         wd_expired;

  assign target = redirect_target & ~32'h3;

  // A request leaves only from FETCH, never while rst is held or when squashed.
  assign imem_req  = (state == FETCH) && !redirect && !rst;
  assign imem_addr = pc;

  assign wd_clear  = imem_req || ((state == WAIT) && redirect && !imem_rvalid);
  assign wd_enable = (state == WAIT) || (state == DRAIN);

  fetch_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) pc <= target;
          else          state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              pc    <= target;
              state <= FETCH;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc          <= pc + PC_STEP;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect) begin
            pc    <= target;
            state <= DRAIN;
          end else if (wd_expired) begin
            fetch_err <= 1'b1;
            state     <= FETCH;
          end
        end
        DRAIN: begin
          // The stale response is dropped; only the latest redirect target survives.
          if (redirect) pc <= target;
          if (imem_rvalid) begin
            state <= FETCH;
          end else if (wd_expired) begin
            fetch_err <= 1'b1;
            state     <= FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= target;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-by-cycle checks of instr_fetch_unit plus timeout and PC-wrap sequences.
module tb_instr_fetch_unit;

  typedef struct {
    logic        rst;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redirect;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_err;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        ready2 = 1'b1;
  logic        err2;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_err       (fetch_err)
  );

  instr_fetch_unit #(
    .RESET_PC    (32'hFFFF_FFFC),
    .TIMEOUT_CYC (4)
  ) dut_wrap (
    .clk             (clk),
    .rst             (rst2),
    .imem_req        (req2),
    .imem_addr       (addr2),
    .imem_rvalid     (rvalid2),
    .imem_rdata      (rdata2),
    .instr_valid     (valid2),
    .instr           (instr2),
    .instr_pc        (pc2),
    .instr_ready     (ready2),
    .redirect        (1'b0),
    .redirect_target (32'h0),
    .fetch_err       (err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic vec(input logic r, input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic rdr, input logic [31:0] tgt, input logic ereq,
                     input logic [31:0] eaddr, input logic ev, input logic [31:0] ei,
                     input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redirect = rdr; v.target = tgt;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_instr = ei; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b1;
  endtask

  initial begin
    // rst, rvalid, rdata, ready, redirect, target | req, addr, valid, instr, instr_pc
    vec(1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h000);
    vec(1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h000);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h000, 0, 32'h0,         32'h000);
    vec(0, 1, 32'hA000_0000, 1, 0, 32'h0,   0, 32'h000, 0, 32'h0,         32'h000);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h004, 1, 32'hA000_0000, 32'h000);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h004, 0, 32'hA000_0000, 32'h000);
    vec(0, 1, 32'hA000_0001, 1, 0, 32'h0,   0, 32'h004, 0, 32'hA000_0000, 32'h000);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h008, 1, 32'hA000_0001, 32'h004);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h008, 0, 32'hA000_0001, 32'h004);
    vec(0, 1, 32'hA000_0002, 1, 0, 32'h0,   0, 32'h008, 0, 32'hA000_0001, 32'h004);
    for (int k = 0; k < 5; k++)
      vec(0, 0, 32'h0,       0, 0, 32'h0,   0, 32'h00C, 1, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h00C, 1, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h00C, 0, 32'hA000_0002, 32'h008);
    // Redirect in WAIT, stale response three cycles later.
    vec(0, 0, 32'h0,         1, 1, 32'h103, 0, 32'h00C, 0, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h100, 0, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h100, 0, 32'hA000_0002, 32'h008);
    vec(0, 1, 32'hDEAD_DEAD, 1, 0, 32'h0,   0, 32'h100, 0, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h100, 0, 32'hA000_0002, 32'h008);
    // Redirect together with rvalid.
    vec(0, 1, 32'hBAD0_0001, 1, 1, 32'h200, 0, 32'h100, 0, 32'hA000_0002, 32'h008);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h200, 0, 32'hA000_0002, 32'h008);
    vec(0, 1, 32'hB000_0000, 1, 0, 32'h0,   0, 32'h200, 0, 32'hA000_0002, 32'h008);
    // Redirect in HOLD without ready.
    vec(0, 0, 32'h0,         0, 1, 32'h300, 0, 32'h204, 1, 32'hB000_0000, 32'h200);
    vec(0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h300, 0, 32'hB000_0000, 32'h200);
    vec(0, 1, 32'hC000_0000, 1, 0, 32'h0,   0, 32'h300, 0, 32'hB000_0000, 32'h200);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h304, 1, 32'hC000_0000, 32'h300);
    // Redirect in FETCH suppresses the request.
    vec(0, 0, 32'h0,         1, 1, 32'h400, 0, 32'h304, 0, 32'hC000_0000, 32'h300);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h400, 0, 32'hC000_0000, 32'h300);
    vec(0, 1, 32'hD000_0000, 1, 0, 32'h0,   0, 32'h400, 0, 32'hC000_0000, 32'h300);
    // Spurious rvalid in HOLD and FETCH is ignored.
    vec(0, 1, 32'hEEEE_EEEE, 0, 0, 32'h0,   0, 32'h404, 1, 32'hD000_0000, 32'h400);
    vec(0, 0, 32'h0,         1, 0, 32'h0,   0, 32'h404, 1, 32'hD000_0000, 32'h400);
    vec(0, 1, 32'hFFFF_0000, 1, 0, 32'h0,   1, 32'h404, 0, 32'hD000_0000, 32'h400);

    @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst             = vecs[i].rst;
      imem_rvalid     = vecs[i].rvalid;
      imem_rdata      = vecs[i].rdata;
      instr_ready     = vecs[i].ready;
      redirect        = vecs[i].redirect;
      redirect_target = vecs[i].target;
      @(negedge clk);
      check($sformatf("v%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      check($sformatf("v%0d imem_addr", i),   imem_addr,            vecs[i].e_addr);
      check($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d instr", i),       instr,                vecs[i].e_instr);
      check($sformatf("v%0d instr_pc", i),    instr_pc,             vecs[i].e_pc);
      check($sformatf("v%0d fetch_err", i),   {31'b0, fetch_err},   32'h0);
    end

    // Timeout: 16 silent WAIT cycles, then a re-request of the same address.
    for (int k = 0; k < 16; k++) begin
      drive_idle();
      @(negedge clk);
      check($sformatf("to%0d imem_req", k),  {31'b0, imem_req},  32'h0);
      check($sformatf("to%0d fetch_err", k), {31'b0, fetch_err}, 32'h0);
    end
    drive_idle();
    @(negedge clk);
    check("to refetch imem_req",  {31'b0, imem_req},  32'h1);
    check("to refetch imem_addr", imem_addr,          32'h404);
    check("to fetch_err set",     {31'b0, fetch_err}, 32'h1);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h5555_0404;
    @(negedge clk);
    check("to resp imem_req", {31'b0, imem_req}, 32'h0);
    drive_idle();
    @(negedge clk);
    check("to resp instr_valid", {31'b0, instr_valid}, 32'h1);
    check("to resp instr",       instr,                32'h5555_0404);
    check("to resp instr_pc",    instr_pc,             32'h404);
    check("to fetch_err sticky", {31'b0, fetch_err},   32'h1);

    // PC wrap and short timeout on the second instance.
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    @(negedge clk);
    check("wrap first req",  {31'b0, req2}, 32'h1);
    check("wrap first addr", addr2,         32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    rvalid2 = 1'b1;
    rdata2  = 32'h1234_5678;
    @(negedge clk);
    check("wrap wait req", {31'b0, req2}, 32'h0);
    @(posedge clk);
    #1;
    rvalid2 = 1'b0;
    @(negedge clk);
    check("wrap hold valid", {31'b0, valid2}, 32'h1);
    check("wrap hold instr", instr2,          32'h1234_5678);
    check("wrap hold pc",    pc2,             32'hFFFF_FFFC);
    check("wrap next pc",    addr2,           32'h0);
    @(posedge clk);
    @(negedge clk);
    check("wrap second req",  {31'b0, req2}, 32'h1);
    check("wrap second addr", addr2,         32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("wrap to%0d req", k), {31'b0, req2}, 32'h0);
      check($sformatf("wrap to%0d err", k), {31'b0, err2}, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    check("wrap refetch req",  {31'b0, req2}, 32'h1);
    check("wrap refetch addr", addr2,         32'h0);
    check("wrap fetch_err",    {31'b0, err2}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
